// File: rtl/pipe_latch_ctrl.sv
// Pipeline latch controller: turns stall, flush, mult/div and memory-wait events
// into per-latch write enables and NOP-insert strobes, plus stall statistics.
module pipe_latch_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_stall,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        load_use,
  output logic        we_pc,
  output logic        we_fd,
  output logic        we_dx,
  output logic        we_xm,
  output logic        we_mw,
  output logic        bub_fd,
  output logic        bub_dx,
  output logic        bub_xm,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic        proto_err
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [31:0]        r_stall_cnt;
  logic               r_proto_err;
  logic               w_multi_evt;

  assign w_multi_evt = (branch_taken & md_start) | (branch_taken & load_use) |
                       (md_start & load_use);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!we_pc && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      // Only simultaneous events in an unfrozen RUN cycle are protocol violations.
      if (r_state == RUN && !mem_stall && w_multi_evt)
        r_proto_err <= 1'b1;
    end
  end

  always_comb begin
    we_pc        = 1'b1;
    we_fd        = 1'b1;
    we_dx        = 1'b1;
    we_xm        = 1'b1;
    we_mw        = 1'b1;
    bub_fd       = 1'b0;
    bub_dx       = 1'b0;
    bub_xm       = 1'b0;
    md_done      = 1'b0;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (reset || mem_stall) begin
      we_pc = 1'b0;
      we_fd = 1'b0;
      we_dx = 1'b0;
      we_xm = 1'b0;
      we_mw = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (branch_taken) begin
            bub_fd = 1'b1;
            bub_dx = 1'b1;
          end else if (md_start) begin
            we_pc        = 1'b0;
            we_fd        = 1'b0;
            we_dx        = 1'b0;
            bub_xm       = 1'b1;
            w_state_next = MD_WAIT;
            w_cnt_next   = CNT_W'(MD_LATENCY - 1);
          end else if (load_use) begin
            we_pc  = 1'b0;
            we_fd  = 1'b0;
            bub_dx = 1'b1;
          end
        end
        MD_WAIT: begin
          if (r_cnt != '0) begin
            we_pc      = 1'b0;
            we_fd      = 1'b0;
            we_dx      = 1'b0;
            bub_xm     = 1'b1;
            w_cnt_next = r_cnt - 1'b1;
          end else begin
            md_done      = 1'b1;
            w_state_next = RUN;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  assign md_busy   = (r_state == MD_WAIT) && !reset;
  assign stall_cnt = r_stall_cnt;
  assign proto_err = r_proto_err;

endmodule
